// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared types and op-classification helpers for the divide controller.
package div_ctrl_pkg;

  localparam int unsigned DIV_XLEN   = 64;
  localparam int unsigned DIV_W_BITS = 32;

  typedef enum logic [2:0] {
    OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW,
    OP_REM, OP_REMU, OP_REMW, OP_REMUW
  } decoded_op_t;

  typedef enum logic [1:0] {DC_IDLE, DC_BUSY, DC_HOLD} divctl_state_t;

  typedef struct packed {
    logic [DIV_XLEN-1:0] a;
    logic [DIV_XLEN-1:0] b;
  } div_core_req_t;

  // W-suffixed ops operate on the low 32 bits
  function automatic logic op_is_w(input decoded_op_t op);
    return op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic op_is_signed(input decoded_op_t op);
    return op inside {OP_DIV, OP_DIVW, OP_REM, OP_REMW};
  endfunction

  function automatic logic op_is_rem(input decoded_op_t op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: execute-stage request/response and divide-core handshake bundle.
interface div_ctrl_if
  import div_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
);
  logic            req_valid;
  decoded_op_t     req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            flush;
  logic            pipe_ready;
  logic            stall_e;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic            core_start;
  logic            core_kill;
  logic [XLEN-1:0] core_a;
  logic [XLEN-1:0] core_b;
  logic            core_done;
  logic [XLEN-1:0] core_quot;
  logic [XLEN-1:0] core_rem;

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, pipe_ready,
    input  core_done, core_quot, core_rem,
    output stall_e, resp_valid, resp_data, core_start, core_kill, core_a, core_b
  );

  modport master (
    output req_valid, req_op, req_a, req_b, flush, pipe_ready,
    output core_done, core_quot, core_rem,
    input  stall_e, resp_valid, resp_data, core_start, core_kill, core_a, core_b
  );
endinterface

// File: rtl/div_sign_fix.sv
// div_sign_fix: operand extension, magnitude conversion and shortcut detection.
module div_sign_fix
  import div_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  decoded_op_t     op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] mag_a_o,
  output logic [XLEN-1:0] mag_b_o,
  output logic            nega_o,
  output logic            negb_o,
  output logic            div_by_zero_o,
  output logic            overflow_o
);
  logic            is_w;
  logic            is_s;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] min_neg;

  // Extend W operands, then fold negative signed operands to magnitudes
  always_comb begin
    is_w  = op_is_w(op_i);
    is_s  = op_is_signed(op_i);
    a_ext = a_i;
    b_ext = b_i;
    if (is_w) begin
      a_ext = {{(XLEN-DIV_W_BITS){is_s & a_i[DIV_W_BITS-1]}}, a_i[DIV_W_BITS-1:0]};
      b_ext = {{(XLEN-DIV_W_BITS){is_s & b_i[DIV_W_BITS-1]}}, b_i[DIV_W_BITS-1:0]};
    end
    nega_o  = is_s & a_ext[XLEN-1];
    negb_o  = is_s & b_ext[XLEN-1];
    mag_a_o = nega_o ? -a_ext : a_ext;
    mag_b_o = negb_o ? -b_ext : b_ext;
    min_neg = is_w ? {{(XLEN-DIV_W_BITS+1){1'b1}}, {(DIV_W_BITS-1){1'b0}}}
                   : {1'b1, {(XLEN-1){1'b0}}};
    div_by_zero_o = (b_ext == '0);
    overflow_o    = is_s && (b_ext == '1) && (a_ext == min_neg);
  end
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: sequences one DIV*/REM* op through an iterative unsigned divide core.
// Optional one-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input logic       clk,
  input logic       reset,
  div_ctrl_if.slave bus
);
  divctl_state_t   state_q;
  decoded_op_t     op_q;
  logic            neg_quot_q;
  logic            neg_rem_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_data_q;
  logic            core_start_q;
  logic            core_kill_q;
  div_core_req_t   core_req_q;

  logic [XLEN-1:0] mag_a, mag_b;
  logic            nega, negb, div_by_zero, overflow;
  logic [XLEN-1:0] shortcut_d;
  logic [XLEN-1:0] core_res_d;
  logic            cache_hit;
  logic [XLEN-1:0] hit_data_d;
  logic            accept;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
    return {{(XLEN-DIV_W_BITS){x[DIV_W_BITS-1]}}, x[DIV_W_BITS-1:0]};
  endfunction

  div_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op_i          (bus.req_op),
    .a_i           (bus.req_a),
    .b_i           (bus.req_b),
    .mag_a_o       (mag_a),
    .mag_b_o       (mag_b),
    .nega_o        (nega),
    .negb_o        (negb),
    .div_by_zero_o (div_by_zero),
    .overflow_o    (overflow)
  );

  assign accept = bus.req_valid && !bus.flush;

  // Architectural results for divide-by-zero and signed overflow, no core needed
  always_comb begin
    logic [XLEN-1:0] a_w;
    a_w = op_is_w(bus.req_op) ? sext_w(bus.req_a) : bus.req_a;
    if (div_by_zero) shortcut_d = op_is_rem(bus.req_op) ? a_w : '1;
    else             shortcut_d = op_is_rem(bus.req_op) ? '0 : a_w;
  end

  // Sign-fix, select and width-fix the core outputs
  always_comb begin
    logic [XLEN-1:0] q, r;
    q          = neg_quot_q ? -bus.core_quot : bus.core_quot;
    r          = neg_rem_q ? -bus.core_rem : bus.core_rem;
    core_res_d = op_is_rem(op_q) ? r : q;
    if (op_is_w(op_q)) core_res_d = sext_w(core_res_d);
  end

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_valid_q;
  decoded_op_t     cache_op_q;
  logic [XLEN-1:0] cache_a_q, cache_b_q, cache_res_q;
  logic [XLEN-1:0] req_a_q, req_b_q;

  assign cache_hit  = cache_valid_q && (cache_op_q == bus.req_op) &&
                      (cache_a_q == bus.req_a) && (cache_b_q == bus.req_b);
  assign hit_data_d = cache_res_q;

  // Capture raw operands at issue and fill the cache on each kept core completion
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid_q <= 1'b0;
      cache_op_q    <= OP_DIV;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
      cache_res_q   <= '0;
      req_a_q       <= '0;
      req_b_q       <= '0;
    end else begin
      if (state_q == DC_IDLE && accept) begin
        req_a_q <= bus.req_a;
        req_b_q <= bus.req_b;
      end
      if (state_q == DC_BUSY && bus.core_done && !bus.flush) begin
        cache_valid_q <= 1'b1;
        cache_op_q    <= op_q;
        cache_a_q     <= req_a_q;
        cache_b_q     <= req_b_q;
        cache_res_q   <= core_res_d;
      end
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign hit_data_d = '0;
`endif

  // Controller FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= DC_IDLE;
      op_q         <= OP_DIV;
      neg_quot_q   <= 1'b0;
      neg_rem_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      core_start_q <= 1'b0;
      core_kill_q  <= 1'b0;
      core_req_q   <= '0;
    end else begin
      core_start_q <= 1'b0;
      core_kill_q  <= 1'b0;
      case (state_q)
        DC_IDLE: begin
          if (accept) begin
            op_q       <= bus.req_op;
            neg_quot_q <= nega ^ negb;
            neg_rem_q  <= nega;
            if (div_by_zero || overflow) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= shortcut_d;
              state_q      <= DC_HOLD;
            end else if (cache_hit) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= hit_data_d;
              state_q      <= DC_HOLD;
            end else begin
              core_req_q.a <= mag_a;
              core_req_q.b <= mag_b;
              core_start_q <= 1'b1;
              state_q      <= DC_BUSY;
            end
          end
        end
        DC_BUSY: begin
          if (bus.flush) begin
            core_kill_q <= 1'b1;
            state_q     <= DC_IDLE;
          end else if (bus.core_done) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= core_res_d;
            state_q      <= DC_HOLD;
          end
        end
        DC_HOLD: begin
          if (bus.flush || bus.pipe_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= DC_IDLE;
          end
        end
        default: state_q <= DC_IDLE;
      endcase
    end
  end

  assign bus.stall_e    = bus.req_valid && !(resp_valid_q && bus.pipe_ready) && !bus.flush;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.core_start = core_start_q;
  assign bus.core_kill  = core_kill_q;
  assign bus.core_a     = core_req_q.a;
  assign bus.core_b     = core_req_q.b;

  // The request must stay up while an op is in flight unless it is flushed
  req_held_a : assert property (@(posedge clk) disable iff (reset)
    (state_q != DC_IDLE) |-> (bus.req_valid || bus.flush));

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed checks of div_ctrl with a hand-driven divide core.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  div_ctrl_if #(.XLEN(64)) bus ();

  div_ctrl #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fire_resp();
    bus.pipe_ready = 1'b1;
    step();
    bus.req_valid  = 1'b0;
    bus.pipe_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_tests++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 64'h0)
      $display("FAIL reset_resp: valid=%b data=%h, want 0/0", bus.resp_valid, bus.resp_data);
    n_tests++;
    if (bus.core_start !== 1'b0 || bus.core_kill !== 1'b0)
      $display("FAIL reset_pulses: start=%b kill=%b, want 0/0", bus.core_start, bus.core_kill);
    n_tests++;
    if (bus.core_a !== 64'h0 || bus.core_b !== 64'h0 || bus.stall_e !== 1'b0)
      $display("FAIL reset_core_ops: a=%h b=%h stall=%b, want 0/0/0", bus.core_a, bus.core_b, bus.stall_e);
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 64'h0) n_fail++;
    if (bus.core_start !== 1'b0 || bus.core_kill !== 1'b0) n_fail++;
    if (bus.core_a !== 64'h0 || bus.core_b !== 64'h0 || bus.stall_e !== 1'b0) n_fail++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_div_neg();
    bit bad = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = OP_DIV;
    bus.req_a = 64'hFFFF_FFFF_FFFF_FFF9; bus.req_b = 64'd2;
    #1;
    n_tests++;
    if (bus.stall_e !== 1'b1) begin
      n_fail++; $display("FAIL div_stall_req: stall=%b, want 1", bus.stall_e);
    end
    step();
    n_tests++;
    if (bus.core_start !== 1'b1 || bus.core_a !== 64'd7 || bus.core_b !== 64'd2) begin
      n_fail++;
      $display("FAIL div_core_ops: start=%b a=%h b=%h, want 1/7/2", bus.core_start, bus.core_a, bus.core_b);
    end
    for (int i = 1; i < 64; i++) begin
      step();
      if (bus.stall_e !== 1'b1 || bus.resp_valid !== 1'b0 || bus.core_start !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL div_wait: stall/valid/start wrong during core wait, got bad=%b want 0", bad);
    end
    bus.core_done = 1'b1; bus.core_quot = 64'd3; bus.core_rem = 64'd1;
    step();
    bus.core_done = 1'b0;
    n_tests++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_fail++;
      $display("FAIL div_neg_result: valid=%b data=%h, want 1/fffffffffffffffd", bus.resp_valid, bus.resp_data);
    end
    bus.pipe_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.stall_e !== 1'b0) begin
      n_fail++; $display("FAIL div_fire_stall: stall=%b, want 0", bus.stall_e);
    end
    step();
    bus.req_valid = 1'b0; bus.pipe_ready = 1'b0;
    n_tests++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL div_after_fire: valid=%b, want 0", bus.resp_valid);
    end
  endtask

  task automatic test_div_zero();
    bus.req_valid = 1'b1; bus.req_op = OP_REMUW;
    bus.req_a = 64'hFFFF_FFFF_0000_0005; bus.req_b = 64'h0;
    step();
    n_tests++;
    if (bus.core_start !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_data !== 64'h5) begin
      n_fail++;
      $display("FAIL remuw_by_zero: start=%b valid=%b data=%h, want 0/1/5", bus.core_start, bus.resp_valid, bus.resp_data);
    end
    fire_resp();
    bus.req_valid = 1'b1; bus.req_op = OP_DIVU;
    bus.req_a = 64'd123; bus.req_b = 64'h0;
    step();
    n_tests++;
    if (bus.core_start !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL divu_by_zero: start=%b valid=%b data=%h, want 0/1/all-ones", bus.core_start, bus.resp_valid, bus.resp_data);
    end
    fire_resp();
  endtask

  task automatic test_overflow();
    bus.req_valid = 1'b1; bus.req_op = OP_DIV;
    bus.req_a = 64'h8000_0000_0000_0000; bus.req_b = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    n_tests++;
    if (bus.core_start !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_data !== 64'h8000_0000_0000_0000) begin
      n_fail++;
      $display("FAIL div_overflow: start=%b valid=%b data=%h, want 0/1/8000000000000000", bus.core_start, bus.resp_valid, bus.resp_data);
    end
    fire_resp();
    bus.req_valid = 1'b1; bus.req_op = OP_REM;
    step();
    n_tests++;
    if (bus.core_start !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_data !== 64'h0) begin
      n_fail++;
      $display("FAIL rem_overflow: start=%b valid=%b data=%h, want 0/1/0", bus.core_start, bus.resp_valid, bus.resp_data);
    end
    fire_resp();
  endtask

  task automatic test_flush();
    bus.req_valid = 1'b1; bus.req_op = OP_DIVU;
    bus.req_a = 64'd100; bus.req_b = 64'd7;
    step();
    n_tests++;
    if (bus.core_start !== 1'b1 || bus.core_a !== 64'd100 || bus.core_b !== 64'd7) begin
      n_fail++;
      $display("FAIL flush_core_ops: start=%b a=%h b=%h, want 1/64/7", bus.core_start, bus.core_a, bus.core_b);
    end
    for (int i = 1; i < 10; i++) step();
    bus.flush = 1'b1; bus.req_valid = 1'b0;
    step();
    bus.flush = 1'b0;
    n_tests++;
    if (bus.core_kill !== 1'b1 || bus.resp_valid !== 1'b0 || dut.state_q !== DC_IDLE) begin
      n_fail++;
      $display("FAIL flush_kill: kill=%b valid=%b state=%0d, want 1/0/0", bus.core_kill, bus.resp_valid, dut.state_q);
    end
    step();
    n_tests++;
    if (bus.core_kill !== 1'b0 || bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_kill_once: kill=%b valid=%b, want 0/0", bus.core_kill, bus.resp_valid);
    end
    // flush coincident with core_done
    bus.req_valid = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    bus.core_done = 1'b1; bus.core_quot = 64'd14; bus.core_rem = 64'd2;
    bus.flush = 1'b1; bus.req_valid = 1'b0;
    step();
    bus.core_done = 1'b0; bus.flush = 1'b0;
    n_tests++;
    if (bus.core_kill !== 1'b1 || bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_with_done: kill=%b valid=%b, want 1/0", bus.core_kill, bus.resp_valid);
    end
    step();
    n_tests++;
    if (bus.resp_valid !== 1'b0 || dut.state_q !== DC_IDLE) begin
      n_fail++; $display("FAIL flush_with_done_idle: valid=%b state=%0d, want 0/0", bus.resp_valid, dut.state_q);
    end
  endtask

  task automatic test_hold_stall();
    bit bad = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = OP_REMW;
    bus.req_a = 64'hFFFF_FFFF_FFFF_FFF7; bus.req_b = 64'd4;
    step();
    n_tests++;
    if (bus.core_start !== 1'b1 || bus.core_a !== 64'd9 || bus.core_b !== 64'd4) begin
      n_fail++;
      $display("FAIL remw_core_ops: start=%b a=%h b=%h, want 1/9/4", bus.core_start, bus.core_a, bus.core_b);
    end
    step();
    bus.core_done = 1'b1; bus.core_quot = 64'd2; bus.core_rem = 64'd1;
    step();
    bus.core_done = 1'b0; bus.core_quot = 64'h0; bus.core_rem = 64'h0;
    for (int i = 0; i < 3; i++) begin
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== 64'hFFFF_FFFF_FFFF_FFFF || bus.stall_e !== 1'b1) bad = 1'b1;
      step();
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL remw_hold: valid/data/stall not held as 1/all-ones/1, bad=%b want 0", bad);
    end
    bus.pipe_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.stall_e !== 1'b0 || bus.resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL remw_fire: stall=%b data=%h, want 0/all-ones", bus.stall_e, bus.resp_data);
    end
    step();
    bus.req_valid = 1'b0; bus.pipe_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 1'b1; bus.req_op = OP_DIVU;
    bus.req_a = 64'd100; bus.req_b = 64'd7;
    step();
    step();
    bus.core_done = 1'b1; bus.core_quot = 64'd14; bus.core_rem = 64'd2;
    step();
    bus.core_done = 1'b0;
    n_tests++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 64'd14) begin
      n_fail++; $display("FAIL b2b_first: valid=%b data=%h, want 1/e", bus.resp_valid, bus.resp_data);
    end
    bus.pipe_ready = 1'b1;
    step();
    bus.pipe_ready = 1'b0;
    n_tests++;
    if (bus.resp_valid !== 1'b0 || bus.core_start !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap: valid=%b start=%b, want 0/0", bus.resp_valid, bus.core_start);
    end
    step();
`ifdef DIV_RESULT_CACHE_EN
    n_tests++;
    if (bus.core_start !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_data !== 64'd14) begin
      n_fail++;
      $display("FAIL b2b_cache_hit: start=%b valid=%b data=%h, want 0/1/e", bus.core_start, bus.resp_valid, bus.resp_data);
    end
`else
    n_tests++;
    if (bus.core_start !== 1'b1 || bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_start: start=%b valid=%b, want 1/0", bus.core_start, bus.resp_valid);
    end
    bus.core_done = 1'b1;
    step();
    bus.core_done = 1'b0;
    n_tests++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 64'd14) begin
      n_fail++; $display("FAIL b2b_second: valid=%b data=%h, want 1/e", bus.resp_valid, bus.resp_data);
    end
`endif
    fire_resp();
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = OP_DIV;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.flush      = 1'b0;
    bus.pipe_ready = 1'b0;
    bus.core_done  = 1'b0;
    bus.core_quot  = '0;
    bus.core_rem   = '0;
    test_reset();
    test_div_neg();
    test_div_zero();
    test_overflow();
    test_flush();
    test_hold_stall();
    test_back_to_back();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the execute stage and an iterative unsigned divide core.
- Accepts one DIV/DIVU/DIVW/DIVUW/REM/REMU/REMW/REMUW request and converts the operands to unsigned magnitudes.
- Starts the core, waits for it, applies the sign fix and width fix, then holds the result until the pipeline accepts it.
- Generates the execute-stage stall, kills in-flight work on flush, and resolves divide-by-zero and signed overflow without using the core.

Parameters:
- XLEN, 64, datapath width; W-ops always operate on bits [31:0].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  divide/remainder op present in execute; held stable until resp fire or flush
- req_op  in  decoded_op_t  one of the eight DIV*/REM* ops
- req_a  in  XLEN  rs1 value
- req_b  in  XLEN  rs2 value
- flush  in  1  pipeline flush/bubble; kills current op
- pipe_ready  in  1  downstream accepts resp this cycle
- stall_e  out  1  hold execute stage
- resp_valid  out  1  result available
- resp_data  out  XLEN  final architectural result
- core_start  out  1  one-cycle start pulse to core
- core_kill  out  1  one-cycle abort pulse to core
- core_a  out  XLEN  unsigned dividend magnitude
- core_b  out  XLEN  unsigned divisor magnitude
- core_done  in  1  one-cycle completion pulse
- core_quot  in  XLEN  unsigned quotient
- core_rem  in  XLEN  unsigned remainder

Behaviour:
- Reset values: state=IDLE; resp_valid=0; resp_data=0; core_start=0; core_kill=0; core_a/core_b=0; latched op and sign flags=0.
- Operand prep:
  - W signed ops sign-extend [31:0]; W unsigned ops zero-extend [31:0].
  - Signed ops take the two's-complement magnitude of each negative operand.
  - Latch neg_q = nega^negb and neg_r = nega.
- IDLE:
  - If req_valid && !flush && b==0, go HOLD. Quotient is all-ones; remainder is a (W: sign-extend a[31:0]).
  - If req_valid && !flush && signed overflow (a=most-negative for width, b=-1), go HOLD. Quotient is a (W: sign-extended); remainder is 0.
  - Otherwise, if req_valid && !flush: drive core_a/core_b, pulse core_start for exactly 1 cycle, go BUSY.
- BUSY:
  - flush: pulse core_kill for 1 cycle, go IDLE. A core_done in the same cycle is discarded (flush wins).
  - core_done && !flush: negate quot if neg_q and rem if neg_r (signed ops only). Select quot or rem by op. W ops sign-extend bit 31. Register into resp_data, go HOLD.
- HOLD:
  - resp_valid=1 and resp_data is stable.
  - pipe_ready: go IDLE and clear resp_valid next cycle.
  - flush: go IDLE with no response.
- stall_e = req_valid && !(resp_valid && pipe_ready) && !flush. It is combinational, so stall drops in the fire cycle.
- Latency:
  - Zero/overflow shortcut: resp_valid one cycle after acceptance.
  - Core path: resp_valid one cycle after core_done.
- Never starts a new op in the cycle of resp fire; IDLE is revisited first, giving a minimum 1-cycle gap.
- Protocol: req_valid dropping without flush while in BUSY/HOLD is illegal; flag it with an assertion.
- Reset mid-BUSY: return to IDLE without pulsing core_kill. The core is reset by the same reset.

Optional Feature:
- DIV_RESULT_CACHE_EN: adds a one-entry cache {valid, op, a, b, result}.
  - Filled at every core-path completion.
  - In IDLE, an exact match on op/a/b goes to HOLD with the cached result next cycle; no core_start.
  - Invalidated by reset only; flush does not invalidate.
- Without the macro: no cache storage; every non-shortcut op uses the core.

Decomposition:
- Package pipes: divctl_state_t {DC_IDLE, DC_BUSY, DC_HOLD}; struct div_core_req_t {a, b}; constant DIV_W_BITS=32.
- Sub-module div_sign_fix (combinational): given op and raw a/b, outputs magnitudes, nega/negb, div_by_zero and overflow flags. Instanced once and reused for the result-sign logic.

Test Plan:
- DIV a=-7, b=2, core_done after 64 cycles: core_a=7, core_b=2; quot 3 negated, resp_data=-3 (0xFFFF_FFFF_FFFF_FFFD); stall_e high for the whole wait.
- REMUW a=0xFFFF_FFFF_0000_0005, b=0: no core_start; resp_valid next cycle; resp_data=0x0000_0000_0000_0005.
- DIV a=0x8000_0000_0000_0000, b=-1: no core_start; resp_data=0x8000_0000_0000_0000. Same operands with REM give 0.
- DIVU 100/7, flush asserted 10 cycles after start: core_kill pulses once; no resp_valid; state IDLE next cycle. Repeat with flush coincident with core_done: result discarded.
- REMW a=-9, b=4, pipe_ready low for 3 cycles in HOLD: resp_data=0xFFFF_FFFF_FFFF_FFFF held stable; stall_e high until the pipe_ready cycle.
- DIV_RESULT_CACHE_EN: DIVU 100/7 twice back-to-back. First uses the core (resp 14); second issues no core_start, resp_valid one cycle after acceptance, resp=14.
